// File: rtl/sys_array_sequencer_if.sv
// Command/result bundle for the systolic job sequencer: the master issues
// weight loads and jobs, the slave (the sequencer) reports status and results.
interface sys_array_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_M    = 2,
    parameter int ARRAY_K    = 5,
    parameter int ARRAY_N    = 2,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(ARRAY_K)
);
    logic                                                   load_w;
    logic [0:ARRAY_M-1][0:ARRAY_K-1][DATA_WIDTH-1:0]        w_data;
    logic                                                   start;
    logic                                                   acc_en;
    logic [0:ARRAY_K-1][0:ARRAY_N-1][DATA_WIDTH-1:0]        a_data;
    logic                                                   busy;
    logic                                                   done;
    logic                                                   cmd_drop;
    logic [0:ARRAY_M-1][0:ARRAY_N-1][ACC_WIDTH-1:0]         out_data;

    modport master (
        output load_w, w_data, start, acc_en, a_data,
        input  busy, done, cmd_drop, out_data
    );

    modport slave (
        input  load_w, w_data, start, acc_en, a_data,
        output busy, done, cmd_drop, out_data
    );
endinterface

// File: rtl/sys_array_sequencer.sv
// Weight-stationary systolic job sequencer computing C = W*A.
// PE(k,i) holds W[i][k]; activations move along i, partial sums move along k.
// Lane k of A is skewed by k cycles on entry, output column i is deskewed by
// M-1-i cycles, so column j of C emerges aligned at job offset K+M+j.
module sys_array_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_M    = 2,
    parameter int ARRAY_K    = 5,
    parameter int ARRAY_N    = 2,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(ARRAY_K),
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    sys_array_sequencer_if.slave  bus
);
    localparam int LAT = ARRAY_N + ARRAY_K + ARRAY_M;
    localparam int CW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    typedef logic [0:ARRAY_M-1][0:ARRAY_K-1][DATA_WIDTH-1:0] wmat_t;
    typedef logic [0:ARRAY_K-1][0:ARRAY_N-1][DATA_WIDTH-1:0] amat_t;
    typedef logic [0:ARRAY_M-1][0:ARRAY_N-1][ACC_WIDTH-1:0]  cmat_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;       // cycles since the start was sampled
    logic          busy_q;
    logic          done_q;
    logic          drop_q;
    logic          acc_q;
    wmat_t         w_q;
    amat_t         a_q;
    cmat_t         out_q;
    cmat_t         res_q;
    cmat_t         res_d;

    logic [DATA_WIDTH-1:0] feed_a [ARRAY_K];
    logic [DATA_WIDTH-1:0] lane_a [ARRAY_K];
    logic [DATA_WIDTH-1:0] a_in   [ARRAY_K][ARRAY_M];
    logic [ACC_WIDTH-1:0]  p_in   [ARRAY_K][ARRAY_M];
    logic [DATA_WIDTH-1:0] act_q  [ARRAY_K][ARRAY_M];
    logic [ACC_WIDTH-1:0]  psum_q [ARRAY_K][ARRAY_M];
    logic [ACC_WIDTH-1:0]  dsk_a  [ARRAY_M];

    logic accept;

    // Commands are honoured only while idle, which includes the DONE cycle.
    assign accept = !busy_q && bus.start;

    // One PE product, widened to the accumulator with the configured signedness.
    function automatic logic [ACC_WIDTH-1:0] pe_mul(input logic [DATA_WIDTH-1:0] w,
                                                    input logic [DATA_WIDTH-1:0] a);
        logic signed [2*DATA_WIDTH-1:0] prod_s;
        logic        [2*DATA_WIDTH-1:0] prod_u;
        prod_s = $signed({{DATA_WIDTH{w[DATA_WIDTH-1]}}, w})
               * $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a});
        prod_u = {{DATA_WIDTH{1'b0}}, w} * {{DATA_WIDTH{1'b0}}, a};
        if (SIGNED) return ACC_WIDTH'(prod_s);
        else        return ACC_WIDTH'(prod_u);
    endfunction

    // Control FSM: command acceptance, job phases and the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            acc_q   <= 1'b0;
            w_q     <= '0;
            out_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the pre-edge values of the other registers.
            done_q <= 1'b0;
            drop_q <= busy_q && (bus.start || bus.load_w);
            if (!busy_q && bus.load_w) begin
                w_q <= bus.w_data;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        acc_q   <= bus.acc_en;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                        state_q <= FEED;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FEED: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ARRAY_N)) state_q <= DRAIN;
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(LAT - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        for (int i = 0; i < ARRAY_M; i++) begin
                            for (int j = 0; j < ARRAY_N; j++) begin
                                out_q[i][j] <= acc_q ? out_q[i][j] + res_d[i][j]
                                                     : res_d[i][j];
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand capture for the job being launched.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; only wavefront-aligned
        // values ever reach a captured sum, so stale contents are harmless.
        if (accept) a_q <= bus.a_data;
    end

    // Column of A presented to the array during FEED, zero otherwise.
    always_comb begin
        // NOTE: default every element first so no path leaves it unassigned.
        for (int k = 0; k < ARRAY_K; k++) feed_a[k] = '0;
        if (state_q == FEED) begin
            for (int k = 0; k < ARRAY_K; k++) begin
                for (int j = 0; j < ARRAY_N; j++) begin
                    if (cnt_q == CW'(j + 1)) feed_a[k] = a_q[k][j];
                end
            end
        end
    end

    genvar gk, gi;

    // Input skew: lane k is delayed k cycles so it meets the partial sum from lane k-1.
    for (gk = 0; gk < ARRAY_K; gk++) begin : g_skew
        if (gk == 0) begin : g_dir
            assign lane_a[gk] = feed_a[gk];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_q [gk];
            // Shift line of length gk.
            always_ff @(posedge clk) begin
                dly_q[0] <= feed_a[gk];
                for (int s = 1; s < gk; s++) dly_q[s] <= dly_q[s-1];
            end
            assign lane_a[gk] = dly_q[gk-1];
        end
    end

    // PE neighbour wiring: activation from the left, partial sum from above.
    for (gk = 0; gk < ARRAY_K; gk++) begin : g_row
        for (gi = 0; gi < ARRAY_M; gi++) begin : g_col
            if (gi == 0) begin : g_a_edge
                assign a_in[gk][gi] = lane_a[gk];
            end else begin : g_a_mid
                assign a_in[gk][gi] = act_q[gk][gi-1];
            end
            if (gk == 0) begin : g_p_edge
                assign p_in[gk][gi] = '0;
            end else begin : g_p_mid
                assign p_in[gk][gi] = psum_q[gk-1][gi];
            end
        end
    end

    // PE array: pass the activation on and add this PE's product to the sum.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ARRAY_K; k++) begin
            for (int i = 0; i < ARRAY_M; i++) begin
                act_q[k][i]  <= a_in[k][i];
                psum_q[k][i] <= p_in[k][i] + pe_mul(w_q[i][k], a_in[k][i]);
            end
        end
    end

    // Output deskew: column i leaves i cycles after column 0, so delay it M-1-i.
    for (gi = 0; gi < ARRAY_M; gi++) begin : g_deskew
        localparam int D = ARRAY_M - 1 - gi;
        if (D == 0) begin : g_dir
            assign dsk_a[gi] = psum_q[ARRAY_K-1][gi];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dly_q [D];
            // Shift line of length M-1-i.
            always_ff @(posedge clk) begin
                dly_q[0] <= psum_q[ARRAY_K-1][gi];
                for (int s = 1; s < D; s++) dly_q[s] <= dly_q[s-1];
            end
            assign dsk_a[gi] = dly_q[D-1];
        end
    end

    // Result collection: aligned column j lands at job offset K+M+j.
    always_comb begin
        res_d = res_q;
        for (int j = 0; j < ARRAY_N; j++) begin
            if (cnt_q == CW'(ARRAY_K + ARRAY_M + j)) begin
                for (int i = 0; i < ARRAY_M; i++) res_d[i][j] = dsk_a[i];
            end
        end
    end

    // Hold the partially collected result between capture cycles.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cmd_drop = drop_q;
    assign bus.out_data = out_q;
endmodule

// File: tb/tb_sys_array_sequencer.sv
// Bench for sys_array_sequencer: an unsigned and a signed instance share one
// directed stimulus stream; a job-level model predicts every output each cycle.
module tb_sys_array_sequencer;
    localparam int DW  = 8;
    localparam int M   = 2;
    localparam int K   = 5;
    localparam int N   = 2;
    localparam int AW  = 2 * DW + $clog2(K);
    localparam int LAT = N + K + M;

    typedef logic [0:M-1][0:K-1][DW-1:0] wmat_t;
    typedef logic [0:K-1][0:N-1][DW-1:0] amat_t;
    typedef logic [0:M-1][0:N-1][AW-1:0] cmat_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  load_w, start, acc_en;
    wmat_t w_data;
    amat_t a_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sys_array_sequencer_if #(.DATA_WIDTH(DW), .ARRAY_M(M), .ARRAY_K(K),
                             .ARRAY_N(N), .ACC_WIDTH(AW)) bus_u ();
    sys_array_sequencer_if #(.DATA_WIDTH(DW), .ARRAY_M(M), .ARRAY_K(K),
                             .ARRAY_N(N), .ACC_WIDTH(AW)) bus_s ();

    assign bus_u.load_w = load_w;
    assign bus_u.w_data = w_data;
    assign bus_u.start  = start;
    assign bus_u.acc_en = acc_en;
    assign bus_u.a_data = a_data;
    assign bus_s.load_w = load_w;
    assign bus_s.w_data = w_data;
    assign bus_s.start  = start;
    assign bus_s.acc_en = acc_en;
    assign bus_s.a_data = a_data;

    sys_array_sequencer #(.DATA_WIDTH(DW), .ARRAY_M(M), .ARRAY_K(K), .ARRAY_N(N),
                          .ACC_WIDTH(AW), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .bus(bus_u));
    sys_array_sequencer #(.DATA_WIDTH(DW), .ARRAY_M(M), .ARRAY_K(K), .ARRAY_N(N),
                          .ACC_WIDTH(AW), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- job-level reference model ----------------
    bit          m_valid = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_drop  = 1'b0;
    bit          m_acc   = 1'b0;
    int          m_rem   = 0;
    wmat_t       m_w     = '0;
    logic [AW-1:0] m_out  [2][M][N];
    logic [AW-1:0] m_prod [2][M][N];

    // Element C[i][j] of W*A with plain integer arithmetic, wrapped to AW bits.
    function automatic logic [AW-1:0] dot(input bit sgn, input wmat_t w, input amat_t a,
                                          input int i, input int j);
        longint s = 0;
        for (int k = 0; k < K; k++) begin
            if (sgn) s += longint'($signed(w[i][k])) * longint'($signed(a[k][j]));
            else     s += longint'(w[i][k]) * longint'(a[k][j]);
        end
        return s[AW-1:0];
    endfunction

    function automatic cmat_t model_out(input int s);
        cmat_t v;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) v[i][j] = m_out[s][i][j];
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit was_busy;
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_drop  = 1'b0;
            m_rem   = 0;
            m_w     = '0;
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < N; j++) m_out[s][i][j] = '0;
        end else begin
            was_busy = m_busy;
            m_done   = 1'b0;
            m_drop   = was_busy && (start || load_w);
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    for (int s = 0; s < 2; s++)
                        for (int i = 0; i < M; i++)
                            for (int j = 0; j < N; j++)
                                m_out[s][i][j] = m_acc ? m_out[s][i][j] + m_prod[s][i][j]
                                                       : m_prod[s][i][j];
                end
            end
            if (!was_busy && load_w) m_w = w_data;
            if (!was_busy && start) begin
                m_acc = acc_en;
                for (int s = 0; s < 2; s++)
                    for (int i = 0; i < M; i++)
                        for (int j = 0; j < N; j++)
                            m_prod[s][i][j] = dot(s == 1, m_w, a_data, i, j);
                m_busy = 1'b1;
                m_rem  = LAT - 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("u.busy",     bus_u.busy,     m_busy);
            check("u.done",     bus_u.done,     m_done);
            check("u.cmd_drop", bus_u.cmd_drop, m_drop);
            check("u.out_data", bus_u.out_data, model_out(0));
            check("s.busy",     bus_s.busy,     m_busy);
            check("s.done",     bus_s.done,     m_done);
            check("s.cmd_drop", bus_s.cmd_drop, m_drop);
            check("s.out_data", bus_s.out_data, model_out(1));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        w_data = '0;
        w_data[0][0] = 8'd1;
        w_data[1][1] = 8'd1;
        a_data = '0;
        a_data[0][0] = 8'd3;
        a_data[0][1] = 8'd4;
        a_data[1][0] = 8'd5;
        a_data[1][1] = 8'd6;
    endtask

    task automatic check_out_u(input string name, input int e00, input int e01,
                               input int e10, input int e11);
        check({name, ".u00"}, bus_u.out_data[0][0], e00);
        check({name, ".u01"}, bus_u.out_data[0][1], e01);
        check({name, ".u10"}, bus_u.out_data[1][0], e10);
        check({name, ".u11"}, bus_u.out_data[1][1], e11);
    endtask

    task automatic check_all_s(input string name, input int e);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) check(name, bus_s.out_data[i][j], e);
    endtask

    initial begin
        reset = 1'b1; load_w = 1'b0; start = 1'b0; acc_en = 1'b0;
        w_data = '0;  a_data = '0;
        step(3);
        reset = 1'b0;
        check("rst.busy", bus_u.busy, 0);
        check("rst.done", bus_u.done, 0);
        check("rst.drop", bus_u.cmd_drop, 0);
        check("rst.out",  bus_u.out_data, 0);

        // Identity job, load_w and start together.
        set_identity(); load_w = 1'b1; start = 1'b1; acc_en = 1'b0;
        step(1);
        load_w = 1'b0; start = 1'b0; a_data = {K*N{8'h55}}; w_data = {M*K{8'hAA}};
        check("id.busy1", bus_u.busy, 1);
        step(7);
        check("id.busy8", bus_u.busy, 1);
        check("id.done8", bus_u.done, 0);
        step(1);
        check("id.done9", bus_u.done, 1);
        check("id.busy9", bus_u.busy, 0);
        check_out_u("id", 3, 4, 5, 6);

        // Accumulate back-to-back from the DONE cycle, then overwrite.
        set_identity(); start = 1'b1; acc_en = 1'b1;
        step(1);
        start = 1'b0; acc_en = 1'b0; a_data = {K*N{8'h33}};
        step(8);
        check("acc.done", bus_u.done, 1);
        check_out_u("acc", 6, 8, 10, 12);
        set_identity(); start = 1'b1; acc_en = 1'b0;
        step(1);
        start = 1'b0;
        step(8);
        check("ovw.done", bus_u.done, 1);
        check_out_u("ovw", 3, 4, 5, 6);

        // Three back-to-back jobs with start held, load_w rejected mid-job.
        set_identity(); start = 1'b1;
        step(4);
        load_w = 1'b1; w_data = {M*K{8'hFF}};
        step(1);
        load_w = 1'b0;
        check("b2b.drop5", bus_u.cmd_drop, 1);
        step(4);
        check("b2b.done9", bus_u.done, 1);
        step(9);
        check("b2b.done18", bus_u.done, 1);
        step(1);
        start = 1'b0;
        step(8);
        check("b2b.done27", bus_u.done, 1);
        check_out_u("b2b", 3, 4, 5, 6);

        // Wrap and sign: W = -1 / 255, A = 127.
        w_data = {M*K{8'hFF}}; a_data = {K*N{8'h7F}}; load_w = 1'b1; start = 1'b1;
        step(1);
        load_w = 1'b0; start = 1'b0;
        step(8);
        check("wrap1.done", bus_s.done, 1);
        check_all_s("wrap.s7f", 32'h7FD85);
        check_out_u("wrap.u7f", 32'h27885, 32'h27885, 32'h27885, 32'h27885);
        w_data = {M*K{8'hFF}}; a_data = {K*N{8'hFF}}; load_w = 1'b1; start = 1'b1;
        step(1);
        load_w = 1'b0; start = 1'b0;
        step(8);
        check_out_u("wrap.uff", 32'h4F605, 32'h4F605, 32'h4F605, 32'h4F605);
        check_all_s("wrap.sff", 5);

        // Reset mid-job, then a fresh job with a simultaneous weight load.
        set_identity(); start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rstj.busy", bus_u.busy, 0);
        check("rstj.done", bus_u.done, 0);
        check("rstj.out",  bus_u.out_data, 0);
        step(1);
        set_identity(); load_w = 1'b1; start = 1'b1;
        step(1);
        load_w = 1'b0; start = 1'b0;
        step(2);
        check("rstj.nodone9", bus_u.done, 0);
        step(6);
        check("rstj.done15", bus_u.done, 1);
        check_out_u("rstj", 3, 4, 5, 6);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_array_sequencer.md
# sys_array_sequencer

Parametrised job sequencer for the weight-stationary systolic matrix multiplier. It computes C = W·A, where W is M×K and A is K×N. It captures operands on a command, generates the skewed feed internally and deskews the column results, then presents the full M×N result with a done pulse. Compared with the previous fetcher it adds:
- a busy/done handshake with back-to-back jobs;
- configurable accumulator width and signedness;
- an accumulate mode for K-tiling;
- rejection and flagging of illegal commands.

## Interface
Parameters:
- DATA_WIDTH, 8, operand element width
- ARRAY_M, 2, rows of W and rows of C
- ARRAY_K, 5, columns of W and rows of A (array depth)
- ARRAY_N, 2, columns of A and columns of C
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(ARRAY_K), result element width
- SIGNED, 0, 1 = two's-complement operands, 0 = unsigned

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- load_w  in  1  capture w_data into the weight registers
- w_data  in  [0:M-1][0:K-1][DATA_WIDTH]  weight matrix W[i][k]
- start  in  1  launch job; captures a_data and acc_en
- acc_en  in  1  at start: 1 = add to held result, 0 = overwrite
- a_data  in  [0:K-1][0:N-1][DATA_WIDTH]  data matrix A[k][j]
- busy  out  1  job in flight
- done  out  1  one-cycle pulse, out_data updated this cycle
- cmd_drop  out  1  one-cycle pulse, a command was rejected
- out_data  out  [0:M-1][0:N-1][ACC_WIDTH]  result C[i][j], held between jobs

## Operation
- States and transitions:
  - IDLE → FEED when start is accepted.
  - FEED lasts N cycles. Column j of A enters the array; lane k is delayed k cycles.
  - DRAIN lasts K+M-1 cycles. Partial sums flush, and lane i of the output is realigned.
  - DONE lasts 1 cycle, then returns to IDLE.
- LAT = N+K+M. Defaults give LAT = 9.
- A command is accepted only when busy = 0. This includes the DONE cycle, which allows back-to-back jobs.
- load_w with busy = 0: W is replaced at the clock edge.
  - If load_w and start are both high in the same cycle, the job uses the new W.
- start with busy = 0: a_data and acc_en are registered and the job begins. Inputs may then change freely.
- load_w or start with busy = 1: the command is ignored, state is unchanged, and cmd_drop pulses the next cycle.
- Arithmetic:
  - Each product is DATA_WIDTH×DATA_WIDTH, signed or unsigned per SIGNED, and extended to ACC_WIDTH.
  - Sums wrap modulo 2^ACC_WIDTH. There is no saturation.
- Accumulate: with acc_en = 1, C_new = C_held + W·A mod 2^ACC_WIDTH. With acc_en = 0, C_new = W·A.
- out_data changes only on the done cycle. It holds that value until the next done or reset.
- The array counter is wide enough for LAT. Nothing wraps inside a job.

## Timing
- Reset values: busy = 0, done = 0, cmd_drop = 0, out_data = 0, W registers = 0, state IDLE.
- Reset during any state aborts the job. All outputs read 0 in the cycle after reset is sampled, and no done is issued for the aborted job.
- Job timeline, with start sampled high at cycle c0:
  - busy is high in cycles c0+1 … c0+LAT-1.
  - done is high in cycle c0+LAT, with busy = 0 and the new out_data valid.
- Throughput: with start held high, consecutive done pulses are exactly LAT cycles apart.
- cmd_drop is asserted in the cycle after the rejected command. It never coincides with done for the same command.

## Test plan
- Identity job (defaults): W row0 = (1,0,0,0,0), row1 = (0,1,0,0,0); A row0 = (3,4), A row1 = (5,6), other rows 0; start at c0.
  - Required: done at c0+9, out_data = [[3,4],[5,6]], busy high for cycles c0+1…c0+8.
- Wrap and sign:
  - SIGNED = 1, all W = 0xFF, all A = 0x7F → every C = 0x7FD85 (−635 mod 2^19).
  - SIGNED = 0, all W = all A = 0xFF → every C = 0x4F605.
- Accumulate: run the identity job, then repeat with acc_en = 1 and the same operands.
  - Required: second done gives [[6,8],[10,12]]. A third job with acc_en = 0 gives [[3,4],[5,6]].
- Back-to-back and drop: hold start high for 3 jobs, and pulse load_w at c0+4.
  - Required: done at c0+9, c0+18 and c0+27; cmd_drop at c0+5; W and results unchanged.
- Reset mid-job: assert reset for one cycle at c0+4.
  - Required: from c0+5, busy = 0, out_data = 0, and no done follows.
  - A new start at c0+6 completes normally, with done at c0+15.
